// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage. It takes the next fetch address from the program
//   counter, runs one read on the instruction memory, and hands the returned
//   word to decode with a valid/ready handshake. A fetch can fail for two
//   reasons: the address is not word aligned, or the memory does not answer
//   within TIMEOUT cycles. Either failure sets a sticky fault flag that stops
//   all further fetching until reset.
//
// Parameters
//   TIMEOUT      number of REQ-state cycles without mem_ack before a fault
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   pc_in        [31:0] byte address of the next instruction
//   flush        branch-taken/redirect; discards in-flight or held instruction
//   mem_req      instruction memory read request
//   mem_addr     [31:0] read address, stable while mem_req=1
//   mem_ack      mem_rdata valid for the current request
//   mem_rdata    [31:0] instruction word from memory
//   instr_valid  instr_out/instr_pc valid toward decode
//   instr_ready  decode accepts the instruction
//   instr_out    [31:0] fetched instruction word
//   instr_pc     [31:0] address instr_out was fetched from
//   pc_advance   one-cycle pulse per accepted instruction (combinational)
//   fault        sticky fetch-error flag
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        pc_advance,
  output logic        fault
);

  // Wide enough to hold TIMEOUT itself, so the count never wraps.
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  // The counter holds the number of unanswered cycles already completed, so
  // the cycle in which it equals TIMEOUT-1 is the last one allowed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t           state,       state_nxt;
  logic             mem_req_nxt;
  logic [31:0]      mem_addr_nxt;
  logic             instr_valid_nxt;
  logic [31:0]      instr_out_nxt;
  logic [31:0]      instr_pc_nxt;
  logic             fault_nxt;
  logic             drop,        drop_nxt;   // flush seen while a read is outstanding
  logic [CNT_W-1:0] wait_cnt,    wait_cnt_nxt;

  // NOTE: every state element is written with non-blocking assignments only,
  // so all registers sample the same pre-edge values of the *_nxt signals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      fault       <= 1'b0;
      drop        <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      mem_req     <= mem_req_nxt;
      mem_addr    <= mem_addr_nxt;
      instr_valid <= instr_valid_nxt;
      instr_out   <= instr_out_nxt;
      instr_pc    <= instr_pc_nxt;
      fault       <= fault_nxt;
      drop        <= drop_nxt;
      wait_cnt    <= wait_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold-current-value default before the case,
    // so no path through the decode leaves one unassigned (no latches).
    state_nxt       = state;
    mem_req_nxt     = mem_req;
    mem_addr_nxt    = mem_addr;
    instr_valid_nxt = instr_valid;
    instr_out_nxt   = instr_out;
    instr_pc_nxt    = instr_pc;
    fault_nxt       = fault;
    drop_nxt        = drop;
    wait_cnt_nxt    = wait_cnt;

    unique case (state)
      S_IDLE: begin
        // flush has nothing to discard here; a late mem_ack is ignored.
        if (!fault) begin
          if (pc_in[1:0] == 2'b00) begin
            mem_addr_nxt = pc_in;
            mem_req_nxt  = 1'b1;
            wait_cnt_nxt = '0;
            drop_nxt     = 1'b0;
            state_nxt    = S_REQ;
          end else begin
            fault_nxt = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          drop_nxt    = 1'b0;
          if (drop || flush) begin
            // The read was redirected away: let it complete, throw it away.
            state_nxt = S_IDLE;
          end else begin
            instr_out_nxt   = mem_rdata;
            instr_pc_nxt    = mem_addr;
            instr_valid_nxt = 1'b1;
            state_nxt       = S_HOLD;
          end
        end else if (wait_cnt == CNT_LAST) begin
          mem_req_nxt = 1'b0;
          fault_nxt   = 1'b1;
          drop_nxt    = 1'b0;
          state_nxt   = S_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
          if (flush) begin
            drop_nxt = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (flush || instr_ready) begin
          instr_valid_nxt = 1'b0;
          state_nxt       = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // A flush in the accept cycle cancels the instruction, so the PC must not step.
  assign pc_advance = (state == S_HOLD) && instr_ready && !flush;

endmodule
